// File: rtl/dcache_wbb_pkg.sv
// Shared types for the data-cache write-back buffer: drain FSM states and
// per-entry bookkeeping.
package dcache_wbb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } wbb_state_e;

  // The entry address lives in its own ADDR_W-wide array beside this struct.
  typedef struct packed {
    logic       valid;
    logic       filling;
    logic       uncached;
    logic [3:0] strb;
  } wbb_meta_t;

  localparam logic [3:0] WBB_STRB_FULL = 4'hf;

endpackage

// File: rtl/dcache_wbb_ram.sv
// Line storage for the write-back buffer: one registered word write port and
// an asynchronous word read port, so drain beats need no read latency.
module dcache_wbb_ram #(
  parameter int DEPTH      = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [$clog2(DEPTH)-1:0]      wentry_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wword_i,
  input  logic [31:0]                   wdata_i,
  input  logic [$clog2(DEPTH)-1:0]      rentry_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rword_i,
  output logic [31:0]                   rdata_o
);

  logic [31:0] mem_q [DEPTH*LINE_WORDS];

  // Data contents are intentionally left unreset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[{wentry_i, wword_i}] <= wdata_i;
  end

  assign rdata_o = mem_q[{rentry_i, rword_i}];

endmodule

// File: rtl/dcache_wb_buffer.sv
// Multi-entry dirty-line / uncached-store write-back buffer between the LSU
// and the cache bus; entries fill one word per cycle and drain in FIFO order.
module dcache_wb_buffer
  import dcache_wbb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic              push_first,
  input  logic              push_last,
  input  logic              push_uncached,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [31:0]       push_data,
  input  logic [3:0]        push_strb,
  input  logic [ADDR_W-1:0] lookup_paddr,
  output logic              lookup_hit,
  input  logic              bus_busy_i,
  output logic              bus_busy_o,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [7:0]        bus_req_len,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  output logic              bus_wlast,
  input  logic              bus_data_ok,
  output logic              empty_o,
  output logic              full_o,
  output wbb_state_e        dbg_state_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int WW  = $clog2(LINE_WORDS);
  localparam int OFF = WW + 2;
  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  wbb_meta_t         meta_q [DEPTH];
  wbb_meta_t         meta_d [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [WW-1:0]     fill_cnt_q, fill_cnt_d, beat_cnt_q, beat_cnt_d;
  wbb_state_e        state_q, state_d;

  logic          push_fire, commit, free, any_filling;
  logic [WW-1:0] fill_idx;
  logic          unused_lookup_lsb;

  assign full_o     = (count_q == (PW+1)'(DEPTH));
  assign push_ready = !full_o;
  assign push_fire  = push_valid & push_ready;
  assign commit     = push_fire & push_last;
  assign fill_idx   = push_first ? '0 : fill_cnt_q;
  assign fill_cnt_d = push_fire ? fill_idx + 1'b1 : fill_cnt_q;
  assign wr_ptr_d   = wr_ptr_q + PW'(commit);
  assign rd_ptr_d   = rd_ptr_q + PW'(free);
  assign count_d    = count_q + (PW+1)'(commit) - (PW+1)'(free);

  always_comb begin
    meta_d = meta_q;
    if (push_fire && push_first) begin
      meta_d[wr_ptr_q].filling  = 1'b1;
      meta_d[wr_ptr_q].uncached = push_uncached;
      meta_d[wr_ptr_q].strb     = push_uncached ? push_strb : WBB_STRB_FULL;
    end
    if (commit) begin
      meta_d[wr_ptr_q].filling = 1'b0;
      meta_d[wr_ptr_q].valid   = 1'b1;
    end
    if (free) meta_d[rd_ptr_q].valid = 1'b0;
  end

  // The entry being drained keeps its valid bit until the final data_ok, so
  // the LSU keeps seeing a conflict for the whole burst.
  always_comb begin
    lookup_hit  = 1'b0;
    any_filling = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_filling = any_filling | meta_q[i].filling;
      if ((meta_q[i].valid || meta_q[i].filling) && !meta_q[i].uncached &&
          addr_q[i][ADDR_W-1:OFF] == lookup_paddr[ADDR_W-1:OFF])
        lookup_hit = 1'b1;
    end
  end
  assign unused_lookup_lsb = ^lookup_paddr[OFF-1:0];
  assign empty_o = (count_q == '0) && !any_filling;

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    bus_req_valid = 1'b0;
    free          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (meta_q[rd_ptr_q].valid && !bus_busy_i) begin
          state_d    = S_ADDR;
          beat_cnt_d = '0;
        end
      end
      S_ADDR: begin
        bus_req_valid = 1'b1;
        if (bus_req_ready) state_d = S_DATA;
      end
      S_DATA: begin
        if (bus_data_ok) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (bus_wlast) begin
            free    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_busy_o   = (state_q != S_IDLE);
  assign bus_req_addr = addr_q[rd_ptr_q];
  assign bus_req_len  = meta_q[rd_ptr_q].uncached ? 8'd0 : LINE_LEN;
  assign bus_wstrb    = meta_q[rd_ptr_q].strb;
  assign bus_wlast    = (state_q == S_DATA) && (8'(beat_cnt_q) == bus_req_len);
  assign dbg_state_o  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) meta_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fill_cnt_q <= '0;
      beat_cnt_q <= '0;
      state_q    <= S_IDLE;
    end else begin
      meta_q     <= meta_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fill_cnt_q <= fill_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      state_q    <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire && push_first) addr_q[wr_ptr_q] <= push_addr;
  end

  dcache_wbb_ram #(
    .DEPTH      (DEPTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_ram (
    .clk      (clk),
    .we_i     (push_fire),
    .wentry_i (wr_ptr_q),
    .wword_i  (fill_idx),
    .wdata_i  (push_data),
    .rentry_i (rd_ptr_q),
    .rword_i  (beat_cnt_q),
    .rdata_o  (bus_wdata)
  );

endmodule
